// File: rtl/cmd_frame_pkg.sv
// Shared definitions for the command framer: opcodes, command encoding,
// frame/response lengths, FSM state encoding and the frame byte selector.
package cmd_frame_pkg;

  typedef enum logic [1:0] {
    CT_RF_WR   = 2'd0,
    CT_RF_RD   = 2'd1,
    CT_ALU_OP  = 2'd2,
    CT_ALU_NOP = 2'd3
  } cmd_type_e;

  localparam logic [7:0] OP_RF_WR   = 8'hAA;
  localparam logic [7:0] OP_RF_RD   = 8'hBB;
  localparam logic [7:0] OP_ALU_OP  = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;

  localparam logic [2:0] FLEN_RF_WR   = 3'd3;
  localparam logic [2:0] FLEN_RF_RD   = 3'd2;
  localparam logic [2:0] FLEN_ALU_OP  = 3'd4;
  localparam logic [2:0] FLEN_ALU_NOP = 3'd2;

  localparam logic [1:0] RLEN_RF_WR   = 2'd0;
  localparam logic [1:0] RLEN_RF_RD   = 2'd1;
  localparam logic [1:0] RLEN_ALU_OP  = 2'd2;
  localparam logic [1:0] RLEN_ALU_NOP = 2'd2;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SEND     = 3'd1;
  localparam logic [2:0] ST_ACK_H    = 3'd2;
  localparam logic [2:0] ST_ACK_L    = 3'd3;
  localparam logic [2:0] ST_WAIT_RSP = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  typedef struct packed {
    cmd_type_e  typ;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] opa;
    logic [7:0] opb;
    logic [3:0] fun;
  } cmd_t;

  function automatic logic [2:0] frame_len(input cmd_type_e t);
    case (t)
      CT_RF_WR:  return FLEN_RF_WR;
      CT_RF_RD:  return FLEN_RF_RD;
      CT_ALU_OP: return FLEN_ALU_OP;
      default:   return FLEN_ALU_NOP;
    endcase
  endfunction

  function automatic logic [1:0] rsp_len(input cmd_type_e t);
    case (t)
      CT_RF_WR:  return RLEN_RF_WR;
      CT_RF_RD:  return RLEN_RF_RD;
      CT_ALU_OP: return RLEN_ALU_OP;
      default:   return RLEN_ALU_NOP;
    endcase
  endfunction

  function automatic logic [7:0] frame_byte(input cmd_t c, input logic [1:0] idx);
    case (c.typ)
      CT_RF_WR:
        case (idx)
          2'd0:    return OP_RF_WR;
          2'd1:    return {4'h0, c.addr};
          default: return c.data;
        endcase
      CT_RF_RD:  return (idx == 2'd0) ? OP_RF_RD : {4'h0, c.addr};
      CT_ALU_OP:
        case (idx)
          2'd0:    return OP_ALU_OP;
          2'd1:    return c.opa;
          2'd2:    return c.opb;
          default: return {4'h0, c.fun};
        endcase
      default:   return (idx == 2'd0) ? OP_ALU_NOP : {4'h0, c.fun};
    endcase
  endfunction

endpackage

// File: rtl/rsp_timeout_cnt.sv
// Response timer: counts enabled cycles up to TIMEOUT_CYC and then flags expiry
// until cleared.
module rsp_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] r_cnt;

  assign o_expire = (r_cnt == CW'(TIMEOUT_CYC));

  // Saturates at expiry so the flag stays up until the owner clears it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                       r_cnt <= '0;
    else if (i_clear)               r_cnt <= '0;
    else if (i_enable && !o_expire) r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/cmd_frame_tx.sv
// Command framer: serialises RF/ALU commands to a UART TX byte stream and
// collects the response bytes. Optional response timeout under RSP_TIMEOUT_EN.
module cmd_frame_tx
  import cmd_frame_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VLD,
  output logic        CMD_RDY,
  input  logic [1:0]  CMD_TYPE,
  input  logic [3:0]  CMD_ADDR,
  input  logic [7:0]  CMD_DATA,
  input  logic [7:0]  CMD_OPA,
  input  logic [7:0]  CMD_OPB,
  input  logic [3:0]  CMD_FUN,
  output logic [7:0]  TX_P_DATA,
  output logic        TX_D_VLD,
  input  logic        TX_BUSY,
  input  logic [7:0]  RX_P_DATA,
  input  logic        RX_D_VLD,
  output logic [15:0] RSP_DATA,
  output logic        RSP_VLD,
  output logic        RSP_ERR,
  output logic        BUSY
);

  if (TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("TIMEOUT_CYC must be at least 1");
  end

  logic [2:0]  r_state;
  cmd_t        r_cmd;
  logic [1:0]  r_idx;
  logic [1:0]  r_rx_cnt;
  logic [7:0]  r_tx_data;
  logic [15:0] r_rsp_data;

  cmd_t w_cmd_in;
  logic w_in_wait;
  logic w_rx_take;
  logic w_rx_last;
  logic w_tmo;

  assign w_cmd_in = '{typ: cmd_type_e'(CMD_TYPE), addr: CMD_ADDR, data: CMD_DATA,
                      opa: CMD_OPA, opb: CMD_OPB, fun: CMD_FUN};
  assign w_in_wait = (r_state == ST_WAIT_RSP);
  assign w_rx_take = w_in_wait & RX_D_VLD;
  assign w_rx_last = w_rx_take & ((r_rx_cnt + 2'd1) == rsp_len(r_cmd.typ));

`ifdef RSP_TIMEOUT_EN
  logic w_tmo_clr;
  logic w_expire;

  // Restart on every received byte so the budget is per byte, not per response.
  assign w_tmo_clr = ~w_in_wait | RX_D_VLD;

  rsp_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .CLK      (CLK),
    .RST      (RST),
    .i_clear  (w_tmo_clr),
    .i_enable (w_in_wait),
    .o_expire (w_expire)
  );

  assign w_tmo = w_in_wait & w_expire & ~RX_D_VLD;
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= ST_IDLE;
      r_cmd      <= '0;
      r_idx      <= '0;
      r_rx_cnt   <= '0;
      r_tx_data  <= '0;
      r_rsp_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE:
          if (CMD_VLD) begin
            r_cmd      <= w_cmd_in;
            r_idx      <= '0;
            r_rx_cnt   <= '0;
            r_rsp_data <= '0;
            r_tx_data  <= frame_byte(w_cmd_in, 2'd0);
            r_state    <= ST_SEND;
          end
        ST_SEND:  if (!TX_BUSY) r_state <= ST_ACK_H;
        ST_ACK_H: if (TX_BUSY)  r_state <= ST_ACK_L;
        ST_ACK_L:
          if (!TX_BUSY) begin
            if ({1'b0, r_idx} < (frame_len(r_cmd.typ) - 3'd1)) begin
              r_idx     <= r_idx + 2'd1;
              r_tx_data <= frame_byte(r_cmd, r_idx + 2'd1);
              r_state   <= ST_SEND;
            end else begin
              r_state <= (rsp_len(r_cmd.typ) == 2'd0) ? ST_DONE : ST_WAIT_RSP;
            end
          end
        ST_WAIT_RSP:
          if (w_rx_take) begin
            if (r_rx_cnt == 2'd0) r_rsp_data[7:0]  <= RX_P_DATA;
            else                  r_rsp_data[15:8] <= RX_P_DATA;
            r_rx_cnt <= r_rx_cnt + 2'd1;
            if (w_rx_last) r_state <= ST_DONE;
          end else if (w_tmo) begin
            r_state <= ST_IDLE;
          end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign CMD_RDY   = (r_state == ST_IDLE);
  assign BUSY      = (r_state != ST_IDLE);
  assign TX_D_VLD  = (r_state == ST_SEND);
  assign TX_P_DATA = r_tx_data;
  assign RSP_DATA  = r_rsp_data;
  assign RSP_VLD   = (r_state == ST_DONE);
  assign RSP_ERR   = w_tmo;

endmodule

// File: doc/cmd_frame_tx.md
CMD_FRAME_TX -- requirements
Module: cmd_frame_tx

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYC, 4096, cycles allowed in WAIT_RSP before timeout.
REQ-002 SHALL have port: CLK  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: RST  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: CMD_VLD  in  1  command request.
REQ-005 SHALL have port: CMD_RDY  out  1  block can accept a command.
REQ-006 SHALL have port: CMD_TYPE  in  2  0=RF_WR, 1=RF_RD, 2=ALU_OP, 3=ALU_NOP.
REQ-007 SHALL have ports: CMD_ADDR in 4, CMD_DATA in 8, CMD_OPA in 8, CMD_OPB in 8, CMD_FUN in 4; command fields.
REQ-008 SHALL have ports: TX_P_DATA out 8, TX_D_VLD out 1, TX_BUSY in 1; byte stream to UART TX.
REQ-009 SHALL have ports: RX_P_DATA in 8, RX_D_VLD in 1; response bytes from UART RX, one-cycle valid.
REQ-010 SHALL have ports: RSP_DATA out 16, RSP_VLD out 1 (pulse), RSP_ERR out 1 (pulse), BUSY out 1 (high when not IDLE).

Function
REQ-011 SHALL capture all CMD_* fields when CMD_VLD & CMD_RDY at a rising edge; CMD_RDY=1 only in IDLE.
REQ-012 SHALL emit frames: RF_WR = AA, {0,ADDR}, DATA; RF_RD = BB, {0,ADDR}; ALU_OP = CC, OPA, OPB, {0,FUN}; ALU_NOP = DD, {0,FUN}.
REQ-013 SHALL use states IDLE, SEND, ACK_H, ACK_L, WAIT_RSP, DONE.
REQ-014 SEND: drive TX_P_DATA=current byte, TX_D_VLD=1; byte accepted at edge where TX_D_VLD=1 and TX_BUSY=0; go ACK_H.
REQ-015 ACK_H: TX_D_VLD=0, TX_P_DATA held; wait TX_BUSY=1, go ACK_L; ACK_L: wait TX_BUSY=0.
REQ-016 From ACK_L: if byte index < frame length-1, increment index, go SEND; else go WAIT_RSP (RF_RD, ALU_*) or DONE (RF_WR).
REQ-017 Byte index 2-bit counter, cleared on command capture; never wraps within a frame.
REQ-018 WAIT_RSP SHALL count RX_D_VLD bytes: RF_RD expects 1, ALU_OP/ALU_NOP expect 2, LSB first.
REQ-019 RSP_DATA: RF_RD = {8'h00, byte0}; ALU = {byte1, byte0}; RF_WR = 16'h0000; held until next command capture.
REQ-020 DONE: RSP_VLD=1 for exactly one cycle, then IDLE; CMD_RDY low in DONE, so minimum command spacing 1 cycle after RSP_VLD.
REQ-021 RX_D_VLD outside WAIT_RSP SHALL be ignored; no state or RSP_DATA change.
REQ-022 RX_D_VLD on the same edge as WAIT_RSP entry SHALL not be counted (counted from first cycle in WAIT_RSP).
REQ-023 CMD_VLD while BUSY SHALL be ignored, not queued.

Reset
REQ-024 On RST low: state=IDLE, CMD_RDY=1, TX_D_VLD=0, TX_P_DATA=0, RSP_DATA=0, RSP_VLD=0, RSP_ERR=0, BUSY=0, counters=0.
REQ-025 Reset mid-frame SHALL abandon the command immediately (TX_D_VLD drops asynchronously); no RSP_VLD/RSP_ERR afterwards.

Configuration
REQ-026 Macro RSP_TIMEOUT_EN defined: cycle counter runs in WAIT_RSP; at TIMEOUT_CYC cycles without full response, pulse RSP_ERR one cycle, RSP_VLD stays 0, return IDLE; counter restarts on each received byte.
REQ-027 Macro undefined: no counter, RSP_ERR tied 0, WAIT_RSP waits indefinitely.

Structure
REQ-028 Shared package cmd_frame_pkg SHALL hold opcodes 8'hAA/BB/CC/DD, CMD_TYPE encoding, frame lengths (3/2/4/2), response lengths (0/1/2/2), state encoding.
REQ-029 Sub-module rsp_timeout_cnt (clear, enable, expire) SHALL implement the timer, instantiated only under RSP_TIMEOUT_EN.

Verification
REQ-030 RF_WR ADDR=5 DATA=3C, TX_BUSY high 10 cycles per byte -> bytes AA,05,3C in order, one RSP_VLD, RSP_DATA=0000.
REQ-031 RF_RD ADDR=2, RX byte 7E -> bytes BB,02; RSP_DATA=007E, RSP_VLD one cycle.
REQ-032 ALU_OP OPA=10 OPB=20 FUN=0, RX 30 then 00 -> bytes CC,10,20,00; RSP_DATA=0030.
REQ-033 ALU_NOP FUN=1, RX bytes sent before WAIT_RSP plus 34,12 after -> early bytes ignored, RSP_DATA=1234.
REQ-034 RSP_TIMEOUT_EN, TIMEOUT_CYC=16, RF_RD with no RX -> RSP_ERR pulse 16 cycles after WAIT_RSP entry, RSP_VLD=0, CMD_RDY=1 next cycle.
REQ-035 RST low during second byte of ALU_OP -> all outputs at reset values; next RF_RD completes normally.
